rename_ctrl: RTL and testbench
==============================

# rename_ctrl

Rename controller for the LEGv8 out-of-order front end. It sequences the `rename_table` write port and owns the physical-register free list. It also keeps the committed (retirement) map, so it can free stale physical registers at commit and rebuild the speculative map after a pipeline flush. It sits between decode and `rename_table`, with the commit port coming from the ROB.

## Interface

Parameters:
- `N_PHYS`, 64: number of physical registers.
- `N_ARCH`, 32: number of architectural registers. Register 31 is XZR and is never renamed.
- `FL_DEPTH`, `N_PHYS-N_ARCH` (32): free-list capacity.

Ports:
- `clk` in, 1: single clock.
- `reset` in, 1: synchronous, active-high.
- `dec_valid` in, 1: decode presents an instruction.
- `dec_ready` out, 1: controller accepts it. A transfer fires when both are high.
- `dec_wr` in, 1: the instruction writes a destination register.
- `dec_rd` in, 5: architectural destination register.
- `ren_phys_rd` out, 6: physical register allocated to the firing instruction. Valid only on a fire that allocates.
- `ren_alloc` out, 1: the current fire allocated a physical register.
- `rt_rename_en` out, 1: write strobe to `rename_table`.
- `rt_arch_rd` out, 5: architectural index for that write.
- `rt_new_phys_rd` out, 6: physical tag for that write.
- `cm_valid` in, 1: ROB commits one instruction with a destination register.
- `cm_arch_rd` in, 5: committed architectural register.
- `cm_phys_rd` in, 6: physical register that instruction was allocated.
- `rt_commit_en` out, 1: commit strobe to `rename_table`.
- `rt_commit_arch_rd` out, 5: commit architectural index to `rename_table`.
- `rt_commit_phys_rd` out, 6: commit physical tag to `rename_table`.
- `flush` in, 1: mispredict or exception recovery. The ROB is empty after it.
- `busy` out, 1: recovery in progress.
- `free_count` out, 6: number of free physical registers, 0..32.

## Operation

**State machine.** Two states, RUN and RECOVER.
- RUN → RECOVER when `flush` is high.
- RECOVER → RUN after the last index is written, with no extra cycle.
- `flush` while in RECOVER restarts the walk at index 0.

**Internal state.**
- Free list: circular buffer `fl[0:31]` of 6-bit tags, with 5-bit `head` and `tail` pointers and a 6-bit `count`. Pointers wrap modulo 32.
- Retirement map: `rrat[0:31]`, 6 bits per entry.

**Allocate (RUN).**
- `dec_ready = RUN && !flush && (!dec_wr || dec_rd==31 || count!=0)`.
- A fire with `dec_wr && dec_rd!=31` allocates:
  - `ren_alloc=1`, `ren_phys_rd=fl[head]`.
  - The same cycle drives `rt_rename_en=1`, `rt_arch_rd=dec_rd`, `rt_new_phys_rd=fl[head]`.
  - At the clock edge: `head++`, `count--`.
- Any other fire (`dec_wr=0`, or `dec_rd==31`) passes through with no allocation and no table write.

**Commit.**
- A commit with `cm_valid && cm_arch_rd!=31` frees the previous committed mapping:
  - `fl[tail] <= rrat[cm_arch_rd]`, `tail++`, `count++`.
  - `rrat[cm_arch_rd] <= cm_phys_rd`.
- `rt_commit_*` mirror `cm_*` combinationally. The enable is gated by `cm_arch_rd!=31`.
- A commit with `cm_arch_rd==31` is ignored.

**Simultaneous allocate and commit.**
- Both pointers move and `count` is unchanged.
- `dec_ready` uses the registered `count`. A tag freed this cycle is not allocatable until the next cycle, so there is no bypass.

**Flush.**
- A commit in the same cycle is applied first, because it is older.
- Then `head <= tail_next` and `count <= 32`. This reclaims every speculative allocation, because their tags still occupy the slots behind the old head.
- Decode fires are blocked (`dec_ready=0`).

**Recover.**
- A 5-bit index walks 0..30, one per cycle.
- Each cycle drives `rt_rename_en=1`, `rt_arch_rd=idx`, `rt_new_phys_rd=rrat[idx]`.
- `busy=1`, `dec_ready=0`.
- `cm_valid` must be low while in RECOVER; the bench asserts this.

## Timing

**Reset values.**
- Registers: `rrat[i]=i`, `fl[k]=32+k`, `head=tail=0`, `count=32`, state RUN.
- Outputs: `busy=0`, `free_count=32`, `rt_rename_en=0`, `ren_alloc=0`, `rt_commit_en=0`.
- `dec_ready=1` in the first cycle after reset deasserts.

**Allocate path.**
- Combinational from `dec_*` to `ren_phys_rd` and `rt_*`, i.e. zero latency.
- `rename_table` captures the write at the same edge that advances `head`.

**Counts and pointers.**
- `free_count` is registered and reflects events one cycle later.
- Underflow is impossible by the `dec_ready` rule.
- Overflow is impossible by construction; a `count>32` assertion covers it.

**Flush and recover.**
- Flush in cycle T: `busy` rises at T+1.
- The walk writes indices 0..30 in cycles T+1..T+31.
- `busy` falls and `dec_ready` returns at T+32.

**Reset mid-recover.** Aborts the walk and returns every register to its reset value.

## Structure

**`rename_pkg`.**
- `N_PHYS`, `N_ARCH`, `XZR=5'd31`.
- `phys_tag_t` (6 bits), `arch_reg_t` (5 bits).
- `state_t` enum `{RUN, RECOVER}`.
- `rename_table` also imports this package.

**Sub-module `free_list`.**
- Circular buffer holding `head`, `tail`, `count` and the storage array.
- Ports: pop, push/push_tag, restore, and outputs `head_tag`, `count`.

**`rename_ctrl` itself.** Holds `rrat`, the FSM and the recover index.

## Test plan

1. **Reset and first allocation.** After reset, fire `dec_wr=1`, `dec_rd=5`.
   - `ren_phys_rd=32`, `rt_rename_en=1`, `rt_arch_rd=5`, `rt_new_phys_rd=32`.
   - Next allocation returns 33; `free_count` reads 31 and then 30.
2. **Exhaustion.** Issue 32 allocating fires.
   - `free_count=0`, `dec_ready=0` for `dec_wr=1`, `dec_rd=7`.
   - `dec_ready=1` for `dec_wr=0`, and for `dec_rd=31` with no table write.
3. **Commit frees the old mapping.** After x5→32, commit `cm_arch_rd=5`, `cm_phys_rd=32`.
   - `rt_commit_en=1`, `free_count` increments, and tag 5 is pushed at `tail`.
   - A commit with `cm_arch_rd=31` changes nothing.
4. **Simultaneous allocate and commit at `free_count=1`.**
   - Allocation returns the head tag, `free_count` stays 1, and the freed tag appears at the tail.
5. **Flush and recovery.** Allocate x5→32, x6→33, x7→34; commit x5/32; then flush.
   - `free_count=32`, `busy=1` for 31 cycles.
   - The walk writes `rt_arch_rd=5`→32 and `rt_arch_rd=6`→6.
   - After the walk: `dec_ready=1`, and the next allocation returns 33.
6. **Reset mid-recover.** Assert `reset` at cycle 10 of the walk.
   - Next cycle: `busy=0`, `free_count=32`, and the next allocation returns 32.

Source files
------------

// File: rtl/rename_pkg.sv
// Shared types and sizing for the rename front end.
// Imported by rename_ctrl, its free list and rename_table.
package rename_pkg;

  localparam int N_PHYS   = 64;
  localparam int N_ARCH   = 32;
  localparam int FL_DEPTH = N_PHYS - N_ARCH;

  typedef logic [5:0] phys_tag_t;
  typedef logic [4:0] arch_reg_t;

  localparam arch_reg_t XZR = 5'd31;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_t;

endpackage

// File: rtl/rename_ctrl_if.sv
// Decode, rename-table and commit signals around rename_ctrl.
// slave is the controller side, master the decode/ROB side.
interface rename_ctrl_if;
  import rename_pkg::*;

  logic      dec_valid;
  logic      dec_ready;
  logic      dec_wr;
  arch_reg_t dec_rd;
  phys_tag_t ren_phys_rd;
  logic      ren_alloc;

  logic      rt_rename_en;
  arch_reg_t rt_arch_rd;
  phys_tag_t rt_new_phys_rd;

  logic      cm_valid;
  arch_reg_t cm_arch_rd;
  phys_tag_t cm_phys_rd;
  logic      rt_commit_en;
  arch_reg_t rt_commit_arch_rd;
  phys_tag_t rt_commit_phys_rd;

  logic      flush;
  logic      busy;
  logic [5:0] free_count;

  modport slave (
    input  dec_valid, dec_wr, dec_rd,
    input  cm_valid, cm_arch_rd, cm_phys_rd,
    input  flush,
    output dec_ready, ren_phys_rd, ren_alloc,
    output rt_rename_en, rt_arch_rd, rt_new_phys_rd,
    output rt_commit_en, rt_commit_arch_rd,
    output rt_commit_phys_rd,
    output busy, free_count
  );

  modport master (
    output dec_valid, dec_wr, dec_rd,
    output cm_valid, cm_arch_rd, cm_phys_rd,
    output flush,
    input  dec_ready, ren_phys_rd, ren_alloc,
    input  rt_rename_en, rt_arch_rd, rt_new_phys_rd,
    input  rt_commit_en, rt_commit_arch_rd,
    input  rt_commit_phys_rd,
    input  busy, free_count
  );

endinterface

// File: rtl/rename_ctrl_free_list.sv
// Circular free list of physical tags.
// restore rewinds head onto the post-push tail, reclaiming all in flight.
module free_list
  import rename_pkg::*;
#(
  parameter int N_ARCH   = 32,
  parameter int FL_DEPTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pop,
  input  logic       push,
  input  phys_tag_t  push_tag,
  input  logic       restore,
  output phys_tag_t  head_tag,
  output logic [5:0] count
);

  localparam int PW = $clog2(FL_DEPTH);

  phys_tag_t     fl [FL_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] tail_next;

  assign tail_next = tail + PW'(push);
  assign head_tag  = fl[head];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < FL_DEPTH; k++) begin
        fl[k] <= phys_tag_t'(N_ARCH + k);
      end
      head  <= '0;
      tail  <= '0;
      count <= 6'(FL_DEPTH);
    end else begin
      if (push) begin
        fl[tail] <= push_tag;
      end
      tail <= tail_next;
      if (restore) begin
        head  <= tail_next;
        count <= 6'(FL_DEPTH);
      end else begin
        head  <= head + PW'(pop);
        count <= count + 6'(push) - 6'(pop);
      end
    end
  end

endmodule

// File: rtl/rename_ctrl.sv
// Rename controller: allocation, retirement map and flush recovery.
// Recovery replays the retirement map into rename_table one entry per cycle.
module rename_ctrl
  import rename_pkg::*;
#(
  parameter int N_PHYS   = 64,
  parameter int N_ARCH   = 32,
  parameter int FL_DEPTH = N_PHYS - N_ARCH
) (
  input logic         clk,
  input logic         reset,
  rename_ctrl_if.slave bus
);

  localparam int TW = $clog2(N_PHYS);
  localparam arch_reg_t LAST = XZR - 5'd1;

  state_t        state;
  arch_reg_t     idx;
  logic [TW-1:0] rrat [N_ARCH];

  logic       run;
  logic       rec;
  logic       fire;
  logic       alloc;
  logic       commit;
  phys_tag_t  head_tag;
  logic [5:0] count;

  assign run = (state == RUN);
  assign rec = (state == RECOVER);

  assign bus.dec_ready = run && !bus.flush &&
    (!bus.dec_wr || bus.dec_rd == XZR || count != '0);

  assign fire   = bus.dec_valid && bus.dec_ready;
  assign alloc  = fire && bus.dec_wr && bus.dec_rd != XZR;
  assign commit = bus.cm_valid && bus.cm_arch_rd != XZR;

  free_list #(
    .N_ARCH  (N_ARCH),
    .FL_DEPTH(FL_DEPTH)
  ) u_fl (
    .clk     (clk),
    .reset   (reset),
    .pop     (alloc),
    .push    (commit),
    .push_tag(phys_tag_t'(rrat[bus.cm_arch_rd])),
    .restore (bus.flush),
    .head_tag(head_tag),
    .count   (count)
  );

  assign bus.ren_alloc   = alloc;
  assign bus.ren_phys_rd = head_tag;

  assign bus.rt_rename_en   = alloc || rec;
  assign bus.rt_arch_rd     = rec ? idx : bus.dec_rd;
  assign bus.rt_new_phys_rd =
    rec ? phys_tag_t'(rrat[idx]) : head_tag;

  assign bus.rt_commit_en      = commit;
  assign bus.rt_commit_arch_rd = bus.cm_arch_rd;
  assign bus.rt_commit_phys_rd = bus.cm_phys_rd;

  assign bus.busy       = rec;
  assign bus.free_count = count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      idx   <= '0;
      for (int i = 0; i < N_ARCH; i++) begin
        rrat[i] <= TW'(i);
      end
    end else begin
      if (commit) begin
        rrat[bus.cm_arch_rd] <= TW'(bus.cm_phys_rd);
      end
      unique case (1'b1)
        bus.flush: begin
          state <= RECOVER;
          idx   <= '0;
        end
        (rec && !bus.flush && idx == LAST): begin
          state <= RUN;
          idx   <= '0;
        end
        (rec && !bus.flush && idx != LAST): begin
          idx <= idx + 5'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rename_ctrl.sv
// Directed bench for rename_ctrl: vector table plus flush/reset sequences.
// Expected tags come from hand-tracked free-list and retirement-map state.
module tb_rename_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  rename_ctrl_if rif ();

  rename_ctrl dut (
    .clk  (clk),
    .reset(reset),
    .bus  (rif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       dv;
    logic       dw;
    logic [4:0] rd;
    logic       cv;
    logic [4:0] ca;
    logic [5:0] cp;
    logic       r;
    logic       a;
    logic [5:0] p;
    logic       ce;
    logic [5:0] fc;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input logic dv, input logic dw, input int rd,
    input logic cv, input int ca, input int cp,
    input logic r, input logic a, input int p,
    input logic ce, input int fc
  );
    vec_t v;
    v.dv = dv; v.dw = dw; v.rd = 5'(rd);
    v.cv = cv; v.ca = 5'(ca); v.cp = 6'(cp);
    v.r = r; v.a = a; v.p = 6'(p);
    v.ce = ce; v.fc = 6'(fc);
    return v;
  endfunction

  task automatic chk(
    input string n,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic dv, input logic dw, input int rd,
    input logic cv, input int ca, input int cp,
    input logic fl
  );
    rif.dec_valid  = dv;
    rif.dec_wr     = dw;
    rif.dec_rd     = 5'(rd);
    rif.cm_valid   = cv;
    rif.cm_arch_rd = 5'(ca);
    rif.cm_phys_rd = 6'(cp);
    rif.flush      = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic alloc_chk(input string n, input int rd,
                           input int tag);
    drive(1, 1, rd, 0, 0, 0, 0);
    #1;
    chk({n, "_ready"}, rif.dec_ready, 1);
    chk({n, "_alloc"}, rif.ren_alloc, 1);
    chk({n, "_phys"}, rif.ren_phys_rd, tag);
    chk({n, "_rtnew"}, rif.rt_new_phys_rd, tag);
    tick();
    idle();
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      assert (rif.free_count <= 6'd32);
      assert (!(rif.busy && rif.cm_valid));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    checks   = 0;
    failures = 0;

    tv.push_back(mk(1,1,5,  0,0,0,  1,1,32, 0,32));
    tv.push_back(mk(1,1,6,  0,0,0,  1,1,33, 0,31));
    for (int k = 2; k < 32; k++) begin
      tv.push_back(mk(1,1,(k+5)%31, 0,0,0,
                      1,1,32+k, 0,32-k));
    end
    tv.push_back(mk(1,1,7,  0,0,0,  0,0,0,  0,0));
    tv.push_back(mk(1,0,7,  0,0,0,  1,0,0,  0,0));
    tv.push_back(mk(1,1,31, 0,0,0,  1,0,0,  0,0));
    tv.push_back(mk(0,0,0,  1,5,32, 1,0,0,  1,0));
    tv.push_back(mk(0,0,0,  1,31,40,1,0,0,  0,1));
    tv.push_back(mk(1,1,8,  1,6,33, 1,1,5,  1,1));
    tv.push_back(mk(1,1,9,  0,0,0,  1,1,6,  0,1));
    tv.push_back(mk(1,1,10, 1,7,34, 0,0,0,  1,0));
    tv.push_back(mk(0,0,0,  0,0,0,  1,0,0,  0,1));

    do_reset();
    rif.dec_wr = 1'b1;
    rif.dec_rd = 5'd5;
    #1;
    chk("rst_busy", rif.busy, 0);
    chk("rst_fc", rif.free_count, 32);
    chk("rst_rten", rif.rt_rename_en, 0);
    chk("rst_alloc", rif.ren_alloc, 0);
    chk("rst_ce", rif.rt_commit_en, 0);
    chk("rst_ready", rif.dec_ready, 1);

    foreach (tv[i]) begin
      drive(tv[i].dv, tv[i].dw, tv[i].rd,
            tv[i].cv, tv[i].ca, tv[i].cp, 0);
      #1;
      chk($sformatf("v%0d_ready", i), rif.dec_ready, tv[i].r);
      chk($sformatf("v%0d_alloc", i), rif.ren_alloc, tv[i].a);
      chk($sformatf("v%0d_rten", i), rif.rt_rename_en, tv[i].a);
      if (tv[i].a) begin
        chk($sformatf("v%0d_phys", i), rif.ren_phys_rd, tv[i].p);
        chk($sformatf("v%0d_rtarch", i), rif.rt_arch_rd, tv[i].rd);
        chk($sformatf("v%0d_rtnew", i), rif.rt_new_phys_rd,
            tv[i].p);
      end
      chk($sformatf("v%0d_ce", i), rif.rt_commit_en, tv[i].ce);
      if (tv[i].ce) begin
        chk($sformatf("v%0d_carch", i), rif.rt_commit_arch_rd,
            tv[i].ca);
        chk($sformatf("v%0d_cphys", i), rif.rt_commit_phys_rd,
            tv[i].cp);
      end
      chk($sformatf("v%0d_fc", i), rif.free_count, tv[i].fc);
      tick();
    end
    idle();

    do_reset();
    alloc_chk("f_a5", 5, 32);
    alloc_chk("f_a6", 6, 33);
    alloc_chk("f_a7", 7, 34);
    drive(0, 0, 0, 1, 5, 32, 0);
    tick();
    drive(1, 1, 10, 0, 0, 0, 1);
    #1;
    chk("f_flush_ready", rif.dec_ready, 0);
    chk("f_flush_rten", rif.rt_rename_en, 0);
    tick();
    idle();
    chk("f_fc", rif.free_count, 32);
    for (int c = 0; c < 31; c++) begin
      chk($sformatf("w%0d_busy", c), rif.busy, 1);
      chk($sformatf("w%0d_rten", c), rif.rt_rename_en, 1);
      chk($sformatf("w%0d_arch", c), rif.rt_arch_rd, c);
      chk($sformatf("w%0d_new", c), rif.rt_new_phys_rd,
          (c == 5) ? 32 : c);
      tick();
    end
    chk("f_end_busy", rif.busy, 0);
    alloc_chk("f_next", 10, 33);

    do_reset();
    alloc_chk("r_a5", 5, 32);
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    idle();
    repeat (10) tick();
    chk("r_w10_arch", rif.rt_arch_rd, 10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("r_busy", rif.busy, 0);
    chk("r_fc", rif.free_count, 32);
    chk("r_rten", rif.rt_rename_en, 0);
    alloc_chk("r_next", 5, 32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
